// File: rtl/register_port_arbiter.sv
// Round-robin arbiter that shares the register file access port among several
// internal requesters, holding each access stable for a fixed number of cycles.
module register_port_arbiter #(
    parameter int NUMBER_OF_REQUESTERS  = 4,
    parameter int REGISTER_NUMBER_WIDTH = 8,
    parameter int DATA_WIDTH            = 32,
    parameter int ACCESS_HOLD_CYCLES    = 3
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic [NUMBER_OF_REQUESTERS-1:0]                   request,
    input  logic [2*NUMBER_OF_REQUESTERS-1:0]                 request_operation,
    input  logic [NUMBER_OF_REQUESTERS*REGISTER_NUMBER_WIDTH-1:0] request_number,
    input  logic [NUMBER_OF_REQUESTERS*DATA_WIDTH-1:0]        request_write_value,
    output logic [NUMBER_OF_REQUESTERS-1:0]                   grant,
    output logic [NUMBER_OF_REQUESTERS-1:0]                   done,
    output logic                                              error,
    output logic [DATA_WIDTH-1:0]                             read_value,
    output logic [1:0]                                        register_operation,
    output logic [REGISTER_NUMBER_WIDTH-1:0]                  register_number,
    output logic [DATA_WIDTH-1:0]                             register_write,
    input  logic [DATA_WIDTH-1:0]                             register_read,
    output logic                                              busy
);

    localparam int N     = NUMBER_OF_REQUESTERS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  pointer_r;
    logic [3:0]        hold_r;

    logic              select_valid_s;
    logic [IDX_W-1:0]  select_index_s;
    logic [1:0]        select_operation_s;
    logic [REGISTER_NUMBER_WIDTH-1:0] select_number_s;
    logic [DATA_WIDTH-1:0]            select_write_s;

    // First set request bit at pointer+1, pointer+2, ... modulo N; {valid, index}.
    function automatic logic [IDX_W:0] round_robin_select(
        input logic [N-1:0]     req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W:0] result;
        int             idx;
        result = {(IDX_W+1){1'b0}};
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                result = {1'b1, IDX_W'(idx)};
            end
        end
        return result;
    endfunction

    function automatic logic [N-1:0] one_hot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] result;
        result = {N{1'b0}};
        result[idx] = 1'b1;
        return result;
    endfunction

    // Pick the next channel and extract its packed request fields.
    always_comb begin
        logic [IDX_W:0] pick;
        pick               = round_robin_select(request, pointer_r);
        select_valid_s     = pick[IDX_W];
        select_index_s     = pick[IDX_W-1:0];
        select_operation_s = request_operation[select_index_s*2 +: 2];
        select_number_s    = request_number[select_index_s*REGISTER_NUMBER_WIDTH +: REGISTER_NUMBER_WIDTH];
        select_write_s     = request_write_value[select_index_s*DATA_WIDTH +: DATA_WIDTH];
    end

    // Arbitration state machine with registered port, grant and completion outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r            <= IDLE;
            pointer_r          <= IDX_W'(N - 1);
            hold_r             <= 4'd0;
            grant              <= {N{1'b0}};
            done               <= {N{1'b0}};
            error              <= 1'b0;
            read_value         <= {DATA_WIDTH{1'b0}};
            register_operation <= 2'd0;
            register_number    <= {REGISTER_NUMBER_WIDTH{1'b0}};
            register_write     <= {DATA_WIDTH{1'b0}};
            busy               <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (select_valid_s) begin
                        pointer_r <= select_index_s;
                        grant     <= one_hot(select_index_s);
                        busy      <= 1'b1;
                        if (select_operation_s == OP_READ || select_operation_s == OP_WRITE) begin
                            state_r            <= ACCESS;
                            hold_r             <= 4'd0;
                            register_operation <= select_operation_s;
                            register_number    <= select_number_s;
                            register_write     <= (select_operation_s == OP_WRITE) ? select_write_s
                                                                                   : {DATA_WIDTH{1'b0}};
                        end else begin
                            state_r <= COMPLETE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (hold_r == 4'(ACCESS_HOLD_CYCLES - 1)) begin
                        if (register_operation == OP_READ) begin
                            read_value <= register_read;
                        end else begin
                            read_value <= read_value;
                        end
                        register_operation <= 2'd0;
                        register_number    <= {REGISTER_NUMBER_WIDTH{1'b0}};
                        register_write     <= {DATA_WIDTH{1'b0}};
                        done               <= grant;
                        error              <= 1'b0;
                        state_r            <= COMPLETE;
                    end else begin
                        hold_r <= hold_r + 4'd1;
                    end
                end
                COMPLETE: begin
                    // An invalid operation arrives here without done set yet, so it
                    // spends one extra cycle to raise done and error together.
                    if (done == {N{1'b0}}) begin
                        done  <= grant;
                        error <= 1'b1;
                    end else begin
                        grant   <= {N{1'b0}};
                        done    <= {N{1'b0}};
                        error   <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r            <= IDLE;
                    grant              <= {N{1'b0}};
                    done               <= {N{1'b0}};
                    error              <= 1'b0;
                    register_operation <= 2'd0;
                    busy               <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_port_arbiter.sv
// Directed bench for register_port_arbiter with hand-computed expectations.
module tb_register_port_arbiter;

    localparam int N  = 4;
    localparam int RW = 8;
    localparam int DW = 32;
    localparam int H  = 3;

    logic            clock;
    logic            reset;
    logic [N-1:0]    request;
    logic [2*N-1:0]  request_operation;
    logic [N*RW-1:0] request_number;
    logic [N*DW-1:0] request_write_value;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            error;
    logic [DW-1:0]   read_value;
    logic [1:0]      register_operation;
    logic [RW-1:0]   register_number;
    logic [DW-1:0]   register_write;
    logic [DW-1:0]   register_read;
    logic            busy;

    int total = 0;
    int bad   = 0;

    register_port_arbiter #(
        .NUMBER_OF_REQUESTERS (N),
        .REGISTER_NUMBER_WIDTH(RW),
        .DATA_WIDTH           (DW),
        .ACCESS_HOLD_CYCLES   (H)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .request            (request),
        .request_operation  (request_operation),
        .request_number     (request_number),
        .request_write_value(request_write_value),
        .grant              (grant),
        .done               (done),
        .error              (error),
        .read_value         (read_value),
        .register_operation (register_operation),
        .register_number    (register_number),
        .register_write     (register_write),
        .register_read      (register_read),
        .busy               (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_channel(input int ch, input logic [1:0] op, input logic [RW-1:0] num,
                               input logic [DW-1:0] wv);
        request_operation[ch*2 +: 2]      = op;
        request_number[ch*RW +: RW]       = num;
        request_write_value[ch*DW +: DW]  = wv;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [N-1:0]  exp_grant;
    logic [RW-1:0] cont_num   [2];
    logic [DW-1:0] cont_value [2];

    initial begin
        reset               = 1'b1;
        request             = 4'b0000;
        request_operation   = 8'h00;
        request_number      = 32'h0;
        request_write_value = 128'h0;
        register_read       = 32'h0;
        do_reset();

        // reset state
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_error", 64'(error), 64'h0);
        check("rst_read_value", 64'(read_value), 64'h0);
        check("rst_op", 64'(register_operation), 64'h0);
        check("rst_num", 64'(register_number), 64'h0);
        check("rst_write", 64'(register_write), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);

        // single read: ch1 reg 9
        set_channel(1, 2'd1, 8'd9, 32'hFFFF_FFFF);
        register_read = 32'h60;
        request = 4'b0010;
        tick();
        request = 4'b0000;
        check("rd_grant", 64'(grant), 64'h2);
        check("rd_op1", 64'(register_operation), 64'h1);
        check("rd_num", 64'(register_number), 64'h9);
        check("rd_write_zero", 64'(register_write), 64'h0);
        check("rd_busy", 64'(busy), 64'h1);
        check("rd_no_done", 64'(done), 64'h0);
        tick();
        check("rd_op2", 64'(register_operation), 64'h1);
        tick();
        check("rd_op3", 64'(register_operation), 64'h1);
        check("rd_num3", 64'(register_number), 64'h9);
        tick();
        check("rd_done", 64'(done), 64'h2);
        check("rd_grant_at_done", 64'(grant), 64'h2);
        check("rd_port_idle", 64'(register_operation), 64'h0);
        check("rd_value", 64'(read_value), 64'h60);
        check("rd_error", 64'(error), 64'h0);
        tick();
        check("rd_idle_grant", 64'(grant), 64'h0);
        check("rd_idle_done", 64'(done), 64'h0);
        check("rd_idle_busy", 64'(busy), 64'h0);

        // contention: ch0 and ch2 writes held, after reset
        do_reset();
        cont_num[0] = 8'd3;   cont_value[0] = 32'hAAAA_0000;
        cont_num[1] = 8'd7;   cont_value[1] = 32'h5555_1234;
        set_channel(0, 2'd2, cont_num[0], cont_value[0]);
        set_channel(2, 2'd2, cont_num[1], cont_value[1]);
        request = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            exp_grant = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            tick();
            check("ct_grant", 64'(grant), 64'(exp_grant));
            check("ct_op", 64'(register_operation), 64'h2);
            check("ct_num", 64'(register_number), 64'(cont_num[k % 2]));
            check("ct_write", 64'(register_write), 64'(cont_value[k % 2]));
            for (int c = 0; c < H - 1; c++) begin
                tick();
                check("ct_onehot", 64'($countones(grant)), 64'h1);
                check("ct_op_hold", 64'(register_operation), 64'h2);
            end
            tick();
            check("ct_done", 64'(done), 64'(exp_grant));
            tick();
            check("ct_idle_grant", 64'(grant), 64'h0);
        end
        request = 4'b0000;

        // invalid operation on ch3
        set_channel(3, 2'd3, 8'd12, 32'h0);
        request = 4'b1000;
        tick();
        request = 4'b0000;
        check("er_grant", 64'(grant), 64'h8);
        check("er_no_port", 64'(register_operation), 64'h0);
        check("er_early_done", 64'(done), 64'h0);
        check("er_busy", 64'(busy), 64'h1);
        tick();
        check("er_done", 64'(done), 64'h8);
        check("er_error", 64'(error), 64'h1);
        check("er_no_port2", 64'(register_operation), 64'h0);
        tick();
        check("er_idle_done", 64'(done), 64'h0);
        check("er_idle_error", 64'(error), 64'h0);
        check("er_idle_grant", 64'(grant), 64'h0);

        // pointer at 3: ch0 beats ch3; then reset in cycle 2 of the access
        set_channel(0, 2'd1, 8'd1, 32'h0);
        set_channel(3, 2'd1, 8'd2, 32'h0);
        request = 4'b1001;
        tick();
        request = 4'b0000;
        check("ptr_grant", 64'(grant), 64'h1);
        tick();
        reset = 1'b1;
        tick();
        check("mr_grant", 64'(grant), 64'h0);
        check("mr_done", 64'(done), 64'h0);
        check("mr_op", 64'(register_operation), 64'h0);
        check("mr_num", 64'(register_number), 64'h0);
        check("mr_busy", 64'(busy), 64'h0);
        check("mr_read_value", 64'(read_value), 64'h0);
        reset = 1'b0;
        tick();
        check("mr_no_done", 64'(done), 64'h0);
        set_channel(1, 2'd1, 8'd2, 32'h0);
        request = 4'b0011;
        tick();
        request = 4'b0000;
        check("mr_ch0_first", 64'(grant), 64'h1);
        tick();
        tick();
        register_read = 32'h11;
        tick();
        check("mr_done_after", 64'(done), 64'h1);
        check("mr_read_after", 64'(read_value), 64'h11);
        tick();

        // withdrawn request: ch1 write reg 4
        set_channel(1, 2'd2, 8'd4, 32'hDEAD_BEEF);
        request = 4'b0010;
        tick();
        request = 4'b0000;
        set_channel(1, 2'd1, 8'h77, 32'h0);
        check("wd_grant", 64'(grant), 64'h2);
        check("wd_op", 64'(register_operation), 64'h2);
        check("wd_write", 64'(register_write), 64'hDEAD_BEEF);
        tick();
        tick();
        check("wd_op3", 64'(register_operation), 64'h2);
        check("wd_num3", 64'(register_number), 64'h4);
        check("wd_write3", 64'(register_write), 64'hDEAD_BEEF);
        tick();
        check("wd_done", 64'(done), 64'h2);
        check("wd_read_kept", 64'(read_value), 64'h11);
        tick();

        // back-to-back reads from ch2
        begin
            int cyc   = 0;
            int last  = 0;
            int dones = 0;
            set_channel(2, 2'd1, 8'd5, 32'h0);
            register_read = 32'h100;
            request = 4'b0100;
            while (dones < 3 && cyc < 40) begin
                tick();
                cyc++;
                check("bb_onehot", 64'($countones(grant) <= 1), 64'h1);
                if (done[2]) begin
                    check("bb_read", 64'(read_value), 64'(32'h100 * (dones + 1)));
                    if (dones > 0) begin
                        check("bb_gap", 64'(cyc - last), 64'(H + 2));
                    end
                    last = cyc;
                    dones++;
                    register_read = 32'h100 * (dones + 1);
                    if (dones == 3) begin
                        request = 4'b0000;
                    end
                end
            end
            check("bb_count", 64'(dones), 64'h3);
            request = 4'b0000;
            tick();
            tick();
            check("bb_idle_busy", 64'(busy), 64'h0);
            check("bb_idle_grant", 64'(grant), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_port_arbiter.md
Name: register_port_arbiter

Overview:
- Shares the single register access port of the AXI slave register file (operation / number / read / write) among several internal requesters.
- Typical requesters: the configuration loader, the frequency-result writer and the diagnostic readback.
- Grants are round-robin. Each access holds the port stable for a fixed number of cycles, so the register file can complete the transfer. The granted requester then gets a one-cycle done pulse, plus the read data for reads.

Parameters:
- NUMBER_OF_REQUESTERS, 4, number of requester channels N (2..8).
- REGISTER_NUMBER_WIDTH, 8, width of a register index.
- DATA_WIDTH, 32, register data width.
- ACCESS_HOLD_CYCLES, 3, cycles the port is driven per access H (1..15).

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- request  in  N  per-channel request level.
- request_operation  in  2N  packed per channel: 0 = none, 1 = read, 2 = write, 3 = reserved.
- request_number  in  N*REGISTER_NUMBER_WIDTH  packed register index per channel.
- request_write_value  in  N*DATA_WIDTH  packed write data per channel.
- grant  out  N  one-hot, high for the granted channel from access start through done.
- done  out  N  one-cycle completion pulse for the granted channel.
- error  out  1  one-cycle pulse coincident with done when the operation was 0 or 3.
- read_value  out  DATA_WIDTH  data captured by the last read; holds until the next read.
- register_operation  out  2  to register file; 0 when idle.
- register_number  out  REGISTER_NUMBER_WIDTH  to register file.
- register_write  out  DATA_WIDTH  to register file.
- register_read  in  DATA_WIDTH  from register file.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset values, applied on the first clock edge with reset high: grant, done, error, read_value, register_operation, register_number, register_write and busy all 0.
  - Round-robin pointer set to N-1, so channel 0 has top priority first.
  - Reset overrides any access in progress; no done pulse is issued for an aborted access.
- States:
  - IDLE: port outputs 0. If any request bit is set, select the first set channel searching pointer+1, pointer+2, ... modulo N.
    - Latch that channel's operation, number and write value; set grant; update pointer to the selected index.
    - Operation 1 or 2: go to ACCESS with hold counter 0.
    - Operation 0 or 3: go to COMPLETE with an error flag set and no port activity.
  - ACCESS: drive register_operation, register_number and register_write from the latched values (register_write is 0 for reads). Increment the hold counter each cycle.
    - On the cycle where the counter equals H-1, capture register_read into read_value if the operation is a read, then go to COMPLETE.
    - The port is driven for exactly H cycles.
  - COMPLETE: port outputs 0, done[granted] = 1, error = error flag. Next cycle: clear grant, done, error; go to IDLE.
- Latency: request sampled high in IDLE at edge t → grant and port driven from cycle t+1 to t+H → done at cycle t+H+1 → IDLE at t+H+2.
  - An error access takes 2 cycles: grant at t+1, done/error at t+2.
- Request fields are sampled only at grant. Changes afterwards, including request dropping, are ignored; the access completes and done is still pulsed.
- A request still high in the IDLE cycle after done is a new request. Because the pointer has advanced, a competing channel wins first.
- Simultaneous requests: exactly one grant. A continuously requesting channel waits at most N-1 accesses.
- grant is always one-hot or zero. done and error are never high outside COMPLETE.
- Channel i's fields occupy bits [i*W +: W] of each packed bus.

Test Plan:
- Single read: H=3, ch1 read reg 9, register_read = 32'h60 → register_number = 9 and operation = 1 for 3 cycles; done[1] on the 4th cycle after the request edge; read_value = 32'h60.
- Contention: ch0 and ch2 writes requested together and held, after reset → order ch0, ch2, ch0, ch2. Each write drives operation 2 with the correct value; grant is never multi-hot.
- Error op: ch3 requests with operation 3 → no port activity; done[3] and error high 2 cycles after the request edge; pointer advances to 3.
- Reset mid-access: assert reset during cycle 2 of an ACCESS → all outputs 0 next edge, no done; after reset, ch0 and ch1 requested together → ch0 is granted.
- Withdrawn request: ch1 write to reg 4, request dropped after grant → the full 3-cycle write occurs and done[1] pulses.
- Back-to-back single requester: ch2 reads with request held for 3 accesses → done pulses H+2 cycles apart; read_value updates on each completion.
